// File: rtl/percept_mac_serial.sv
// percept_mac_serial: serially loaded N-pair signed MAC with step activation and serial result readout
module percept_mac_serial #(
  parameter int SIZE  = 16,
  parameter int N     = 4,
  parameter int ACC_W = 40
) (
  input  logic clk,
  input  logic nRst,
  input  logic rx,
  input  logic load_en,
  input  logic load_sel,
  input  logic start,
  input  logic shift_out,
  output logic busy,
  output logic done,
  output logic fire,
  output logic tx
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = N * SIZE;
  typedef enum logic {IDLE, MAC} state_t;
  state_t state, state_nx;
  logic [BW-1:0] w_bank, x_bank;
  logic signed [ACC_W-1:0] acc, sum, prod_ext;
  logic [ACC_W-1:0] res_sh;
  logic [IW-1:0] idx;
  logic signed [SIZE-1:0] w_cur, x_cur;
  logic signed [2*SIZE-1:0] prod;
  logic last;
  assign w_cur    = w_bank[idx*SIZE +: SIZE];
  assign x_cur    = x_bank[idx*SIZE +: SIZE];
  assign prod     = w_cur * x_cur;
  assign prod_ext = ACC_W'(prod);
  assign sum      = acc + prod_ext;
  assign last     = (idx == IW'(N - 1));
  assign busy     = (state == MAC);
  assign tx       = res_sh[ACC_W-1];
  // State register; reset mid-pass simply drops back to IDLE
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) state <= IDLE;
    else state <= state_nx;
  // Next state: start launches a pass, the last pair ends it
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (start ? MAC : IDLE) : (last ? IDLE : MAC);
  end
  // Datapath: bank shift chains and readout in IDLE, accumulate and complete in MAC
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) begin
      w_bank <= '0;
      x_bank <= '0;
      acc    <= '0;
      res_sh <= '0;
      idx    <= '0;
      done   <= 1'b0;
      fire   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          acc <= '0;
          idx <= '0;
        end else if (load_en) begin
          if (load_sel) x_bank <= {x_bank[BW-2:0], rx};
          else w_bank <= {w_bank[BW-2:0], rx};
        end
        if (shift_out) res_sh <= {res_sh[ACC_W-2:0], 1'b0};
      end else begin
        acc <= sum;
        idx <= idx + 1'b1;
        if (last) begin
          res_sh <= sum;
          fire   <= !sum[ACC_W-1] && (|sum);
          done   <= 1'b1;
        end
      end
    end
endmodule
